// File: rtl/idex_pkg.sv
// rtl/idex_pkg.sv - control bundle width and field indices shared by decoder, ID/EX and EX
package idex_pkg;

  localparam int CTRL_W         = 12;
  localparam int CTRL_REGWRITE  = 0;
  localparam int CTRL_MEMREAD   = 1;
  localparam int CTRL_MEMWRITE  = 2;
  localparam int CTRL_MEMTOREG  = 3;
  localparam int CTRL_ALUSRC    = 4;
  localparam int CTRL_BRANCH    = 5;
  localparam int CTRL_JUMP      = 6;
  localparam int CTRL_ALUOP_LSB = 7;
  localparam int CTRL_ALUOP_MSB = 10;
  localparam int CTRL_SPARE     = 11;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard detect between ID and EX
module load_use_detect (
  input  logic       idValid,
  input  logic [4:0] idRs1Addr,
  input  logic [4:0] idRs2Addr,
  input  logic       idUsesRs1,
  input  logic       idUsesRs2,
  input  logic       exValid,
  input  logic       exMemRead,
  input  logic [4:0] exRdAddr,
  output logic       loadUse
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = idUsesRs1 && (idRs1Addr == exRdAddr);
  assign rs2_hit = idUsesRs2 && (idRs2Addr == exRdAddr);

  // x0 is hardwired to zero, so a load targeting it never produces a dependency
  assign loadUse = idValid && exValid && exMemRead && (exRdAddr != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble, flush and EX hold
// Optional performance counters: define IDEX_PERF_CNT_EN
module id_ex_stage
  import idex_pkg::CTRL_MEMREAD;
#(
  parameter int CTRL_W = idex_pkg::CTRL_W,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              idValid,
  input  logic [XLEN-1:0]   idPc,
  input  logic [XLEN-1:0]   idImm,
  input  logic [4:0]        idRs1Addr,
  input  logic [4:0]        idRs2Addr,
  input  logic [4:0]        idRdAddr,
  input  logic              idUsesRs1,
  input  logic              idUsesRs2,
  input  logic [XLEN-1:0]   idRs1Data,
  input  logic [XLEN-1:0]   idRs2Data,
  input  logic [CTRL_W-1:0] idCtrl,
  input  logic              flush,
  input  logic              exStall,
  output logic              exValid,
  output logic [XLEN-1:0]   exPc,
  output logic [XLEN-1:0]   exImm,
  output logic [XLEN-1:0]   exRs1Data,
  output logic [XLEN-1:0]   exRs2Data,
  output logic [4:0]        exRs1Addr,
  output logic [4:0]        exRs2Addr,
  output logic [4:0]        exRdAddr,
  output logic [CTRL_W-1:0] exCtrl,
  output logic              idStall
`ifdef IDEX_PERF_CNT_EN
  ,
  output logic [31:0]       loadUseCnt,
  output logic [31:0]       flushCnt
`endif
);

  logic load_use;
  logic bubble;

  load_use_detect u_load_use_detect (
    .idValid   (idValid),
    .idRs1Addr (idRs1Addr),
    .idRs2Addr (idRs2Addr),
    .idUsesRs1 (idUsesRs1),
    .idUsesRs2 (idUsesRs2),
    .exValid   (exValid),
    .exMemRead (exCtrl[CTRL_MEMREAD]),
    .exRdAddr  (exRdAddr),
    .loadUse   (load_use)
  );

  assign bubble  = !flush && !exStall && load_use;
  assign idStall = rstn && !flush && (exStall || load_use);

  always_ff @(posedge clk) begin
    if (!rstn || flush || bubble) begin
      // reset, flush and bubble all leave an empty slot with zeroed payload
      exValid   <= 1'b0;
      exCtrl    <= '0;
      exPc      <= '0;
      exImm     <= '0;
      exRs1Data <= '0;
      exRs2Data <= '0;
      exRs1Addr <= '0;
      exRs2Addr <= '0;
      exRdAddr  <= '0;
    end else if (!exStall) begin
      exValid   <= idValid;
      exCtrl    <= idValid ? idCtrl : '0;
      exPc      <= idPc;
      exImm     <= idImm;
      exRs1Data <= idRs1Data;
      exRs2Data <= idRs2Data;
      exRs1Addr <= idRs1Addr;
      exRs2Addr <= idRs2Addr;
      exRdAddr  <= idRdAddr;
    end
  end

`ifdef IDEX_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      loadUseCnt <= '0;
      flushCnt   <= '0;
    end else begin
      if (bubble && (loadUseCnt != 32'hFFFF_FFFF)) loadUseCnt <= loadUseCnt + 32'd1;
      if (flush && idValid && (flushCnt != 32'hFFFF_FFFF)) flushCnt <= flushCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage using directed vectors
module tb_id_ex_stage;

  localparam logic [11:0] ADD  = 12'h101;
  localparam logic [11:0] ADDI = 12'h111;
  localparam logic [11:0] LW   = 12'h01B;

  typedef struct packed {
    logic        valid;
    logic        zero;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [11:0] ctrl;
    logic [31:0] lu;
    logic [31:0] fl;
  } ex_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        idValid = 1'b0;
  logic [31:0] idPc = '0, idImm = '0, idRs1Data = '0, idRs2Data = '0;
  logic [4:0]  idRs1Addr = '0, idRs2Addr = '0, idRdAddr = '0;
  logic        idUsesRs1 = 1'b0, idUsesRs2 = 1'b0;
  logic [11:0] idCtrl = '0;
  logic        flush = 1'b0, exStall = 1'b0;
  logic        exValid, idStall;
  logic [31:0] exPc, exImm, exRs1Data, exRs2Data;
  logic [4:0]  exRs1Addr, exRs2Addr, exRdAddr;
  logic [11:0] exCtrl;
  logic [31:0] loadUseCnt, flushCnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic stall_q[$];
  ex_t  ex_q[$];
  logic s_exp;
  ex_t  e;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rstn(rstn), .idValid(idValid), .idPc(idPc), .idImm(idImm),
    .idRs1Addr(idRs1Addr), .idRs2Addr(idRs2Addr), .idRdAddr(idRdAddr),
    .idUsesRs1(idUsesRs1), .idUsesRs2(idUsesRs2),
    .idRs1Data(idRs1Data), .idRs2Data(idRs2Data), .idCtrl(idCtrl),
    .flush(flush), .exStall(exStall), .exValid(exValid), .exPc(exPc), .exImm(exImm),
    .exRs1Data(exRs1Data), .exRs2Data(exRs2Data), .exRs1Addr(exRs1Addr),
    .exRs2Addr(exRs2Addr), .exRdAddr(exRdAddr), .exCtrl(exCtrl), .idStall(idStall)
`ifdef IDEX_PERF_CNT_EN
    , .loadUseCnt(loadUseCnt), .flushCnt(flushCnt)
`endif
  );

`ifndef IDEX_PERF_CNT_EN
  assign loadUseCnt = '0;
  assign flushCnt   = '0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // operand payloads are a fixed function of the PC so held/captured data can be checked
  function automatic logic [31:0] imm_of(input logic [31:0] pc);
    return pc ^ 32'h0000_0F00;
  endfunction
  function automatic logic [31:0] d1_of(input logic [31:0] pc);
    return pc + 32'h1000_0000;
  endfunction
  function automatic logic [31:0] d2_of(input logic [31:0] pc);
    return ~pc;
  endfunction

  task automatic step(input logic r, input logic f, input logic s, input logic v,
                      input logic [31:0] pc, input logic [4:0] a1, input logic u1,
                      input logic [4:0] a2, input logic u2, input logic [4:0] rd,
                      input logic [11:0] ctrl, input logic es, input ex_t ee);
    rstn = r; flush = f; exStall = s; idValid = v;
    idPc = pc; idImm = imm_of(pc); idRs1Data = d1_of(pc); idRs2Data = d2_of(pc);
    idRs1Addr = a1; idUsesRs1 = u1; idRs2Addr = a2; idUsesRs2 = u2; idRdAddr = rd; idCtrl = ctrl;
    stall_q.push_back(es);
    @(posedge clk);
    ex_q.push_back(ee);
    #1;
  endtask

  always @(negedge clk) begin
    if (stall_q.size() > 0) begin
      s_exp = stall_q.pop_front();
      check("idStall", {31'b0, idStall}, {31'b0, s_exp});
    end
    if (ex_q.size() > 0) begin
      e = ex_q.pop_front();
      check("exValid", {31'b0, exValid}, {31'b0, e.valid});
      check("exCtrl", {20'b0, exCtrl}, {20'b0, e.ctrl});
      if (e.valid) begin
        check("exPc", exPc, e.pc);
        check("exImm", exImm, imm_of(e.pc));
        check("exRs1Data", exRs1Data, d1_of(e.pc));
        check("exRs2Data", exRs2Data, d2_of(e.pc));
        check("exRs1Addr", {27'b0, exRs1Addr}, {27'b0, e.rs1});
        check("exRs2Addr", {27'b0, exRs2Addr}, {27'b0, e.rs2});
        check("exRdAddr", {27'b0, exRdAddr}, {27'b0, e.rd});
      end else if (e.zero) begin
        check("exPc_zero", exPc, 32'h0);
        check("exRs1Data_zero", exRs1Data, 32'h0);
        check("exRdAddr_zero", {27'b0, exRdAddr}, 32'h0);
      end
`ifdef IDEX_PERF_CNT_EN
      check("loadUseCnt", loadUseCnt, e.lu);
      check("flushCnt", flushCnt, e.fl);
`endif
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    //    r f s v pc          a1 u a2 u rd ctrl  es  {valid,zero,pc,rs1,rs2,rd,ctrl,lu,fl}
    step(0,0,0,1,32'h100, 2,1, 3,1, 1,ADD, 0, '{0,1,32'h0,   5'd0, 5'd0, 5'd0, 12'h0, 32'd0,32'd0});
    step(1,0,0,1,32'h100, 2,1, 3,1, 1,ADD, 0, '{1,0,32'h100, 5'd2, 5'd3, 5'd1, ADD,   32'd0,32'd0});
    step(1,0,0,1,32'h104, 1,1, 2,1, 4,ADD, 0, '{1,0,32'h104, 5'd1, 5'd2, 5'd4, ADD,   32'd0,32'd0});
    step(1,0,0,1,32'h108, 1,1, 0,0, 5,LW,  0, '{1,0,32'h108, 5'd1, 5'd0, 5'd5, LW,    32'd0,32'd0});
    step(1,0,0,1,32'h10C, 5,1, 7,1, 6,ADD, 1, '{0,0,32'h0,   5'd0, 5'd0, 5'd0, 12'h0, 32'd1,32'd0});
    step(1,0,0,1,32'h10C, 5,1, 7,1, 6,ADD, 0, '{1,0,32'h10C, 5'd5, 5'd7, 5'd6, ADD,   32'd1,32'd0});
    step(1,0,0,1,32'h110, 1,1, 0,0, 0,LW,  0, '{1,0,32'h110, 5'd1, 5'd0, 5'd0, LW,    32'd1,32'd0});
    step(1,0,0,1,32'h114, 0,1, 0,1, 8,ADD, 0, '{1,0,32'h114, 5'd0, 5'd0, 5'd8, ADD,   32'd1,32'd0});
    step(1,0,0,1,32'h118, 1,1, 0,0, 5,LW,  0, '{1,0,32'h118, 5'd1, 5'd0, 5'd5, LW,    32'd1,32'd0});
    step(1,0,0,1,32'h11C, 9,1, 5,0,10,ADDI,0, '{1,0,32'h11C, 5'd9, 5'd5, 5'd10,ADDI,  32'd1,32'd0});
    step(1,0,0,1,32'h120, 1,1, 0,0, 5,LW,  0, '{1,0,32'h120, 5'd1, 5'd0, 5'd5, LW,    32'd1,32'd0});
    step(1,1,0,1,32'h124, 5,1, 7,1, 6,ADD, 0, '{0,1,32'h0,   5'd0, 5'd0, 5'd0, 12'h0, 32'd1,32'd1});
    step(1,0,0,1,32'h128, 1,1, 0,0,10,LW,  0, '{1,0,32'h128, 5'd1, 5'd0, 5'd10,LW,    32'd1,32'd1});
    for (int i = 0; i < 3; i++)
      step(1,0,1,1,32'h12C, 3,1,10,1,11,ADD, 1, '{1,0,32'h128, 5'd1, 5'd0, 5'd10,LW,  32'd1,32'd1});
    step(1,0,0,1,32'h12C, 3,1,10,1,11,ADD, 1, '{0,0,32'h0,   5'd0, 5'd0, 5'd0, 12'h0, 32'd2,32'd1});
    step(1,0,0,1,32'h12C, 3,1,10,1,11,ADD, 0, '{1,0,32'h12C, 5'd3, 5'd10,5'd11,ADD,   32'd2,32'd1});
    step(1,0,0,1,32'h130, 1,1, 0,0,11,LW,  0, '{1,0,32'h130, 5'd1, 5'd0, 5'd11,LW,    32'd2,32'd1});
    step(1,1,1,1,32'h134,11,1, 2,1,12,ADD, 0, '{0,1,32'h0,   5'd0, 5'd0, 5'd0, 12'h0, 32'd2,32'd2});
    step(1,1,0,0,32'h138, 1,1, 0,0,12,LW,  0, '{0,1,32'h0,   5'd0, 5'd0, 5'd0, 12'h0, 32'd2,32'd2});
    step(1,0,0,1,32'h138, 1,1, 0,0,12,LW,  0, '{1,0,32'h138, 5'd1, 5'd0, 5'd12,LW,    32'd2,32'd2});
    step(1,0,1,1,32'h13C,12,1, 0,0,13,ADD, 1, '{1,0,32'h138, 5'd1, 5'd0, 5'd12,LW,    32'd2,32'd2});
    step(0,0,1,1,32'h13C,12,1, 0,0,13,ADD, 0, '{0,1,32'h0,   5'd0, 5'd0, 5'd0, 12'h0, 32'd0,32'd0});
    step(1,0,0,1,32'h140, 2,1, 3,1, 1,ADD, 0, '{1,0,32'h140, 5'd2, 5'd3, 5'd1, ADD,   32'd0,32'd0});
    step(1,0,0,0,32'h144, 2,1, 3,1, 1,ADD, 0, '{0,0,32'h0,   5'd0, 5'd0, 5'd0, 12'h0, 32'd0,32'd0});
    step(1,0,0,1,32'h148, 1,1, 0,0,13,LW,  0, '{1,0,32'h148, 5'd1, 5'd0, 5'd13,LW,    32'd0,32'd0});
    step(1,0,0,0,32'h14C,13,1,13,1,14,ADD, 0, '{0,0,32'h0,   5'd0, 5'd0, 5'd0, 12'h0, 32'd0,32'd0});
    step(1,0,0,1,32'h150,13,1, 0,0,14,ADD, 0, '{1,0,32'h150, 5'd13,5'd0, 5'd14,ADD,   32'd0,32'd0});
    @(negedge clk); #1;
    check("ex_q_drained", ex_q.size(), 32'd0);
    check("stall_q_drained", stall_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
